fifo_ring_param: RTL and testbench
==================================

# fifo_ring_param

Parametrised synchronous circular FIFO: the next generation of the team's cyclic FIFO. Adds selectable overwrite-on-full mode, programmable almost-full/almost-empty thresholds, an occupancy count and a synchronous flush. Sits between a producer and a consumer in one clock domain. Depth and width are set per instance.

## Interface

- DATA, 8, data word width in bits
- ADDR, 4, address width; DEPTH = 2**ADDR entries
- AF_LEVEL, 2**ADDR-2, fifo_almost_full asserts when count >= AF_LEVEL (range 1..DEPTH)
- AE_LEVEL, 2, fifo_almost_empty asserts when count <= AE_LEVEL (range 0..DEPTH-1)
- OVERWRITE, 0, 0 = drop writes when full; 1 = write when full overwrites the oldest entry
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous clear of contents and pointers
- write_data  in  DATA  write word
- write_req  in  1  write request
- read_req  in  1  read request
- read_data  out  DATA  registered read word
- read_data_valid  out  1  read_data holds a newly popped word this cycle
- fifo_count  out  ADDR+1  occupancy, 0..DEPTH
- fifo_empty  out  1  count == 0
- fifo_full  out  1  count == DEPTH
- fifo_almost_full  out  1  count >= AF_LEVEL
- fifo_almost_empty  out  1  count <= AE_LEVEL
- fifo_of  out  1  one-cycle pulse: write request hit a full FIFO
- fifo_uf  out  1  one-cycle pulse: read request hit an empty FIFO

## Operation

- Storage: DEPTH x DATA register array, not reset. ADDR-bit wr_ptr and rd_ptr wrap DEPTH-1 -> 0 by natural overflow. Registered count is ADDR+1 bits.
- Priority per edge: rst > flush > requests.
- rst or flush: wr_ptr = rd_ptr = 0, count = 0, read_data_valid = 0, fifo_of = fifo_uf = 0. rst also clears read_data to 0. flush leaves read_data unchanged and ignores requests in the same cycle.
- Write accepted when write_req and (count < DEPTH, or read accepted in the same cycle). Stores write_data at wr_ptr and increments wr_ptr.
- Read accepted when read_req and count > 0. Loads mem[rd_ptr] into read_data, pulses read_data_valid and increments rd_ptr. No write-to-read bypass: read on empty is rejected even with a simultaneous write.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Full and write_req without read_req:
  - OVERWRITE=0: write dropped; fifo_of pulses.
  - OVERWRITE=1: write stores at wr_ptr (== rd_ptr). Both pointers increment, count stays DEPTH, the oldest entry is lost, fifo_of pulses.
- Full with read_req and write_req: normal read plus write, no fifo_of, in both modes.
- Empty with read_req: read_data holds, read_data_valid = 0, fifo_uf pulses. A simultaneous write is still accepted.
- Status flags decode the registered count combinationally, so they are glitch-free relative to clk.

## Timing

- Reset values: read_data = 0, read_data_valid = 0, fifo_count = 0, fifo_empty = 1, fifo_full = 0, fifo_almost_full = 0, fifo_almost_empty = 1, fifo_of = 0, fifo_uf = 0.
- Write sampled at edge n: count and flags update after edge n. The word can be read by a read_req sampled at edge n+1.
- Read sampled at edge n: read_data and read_data_valid are valid in the cycle after edge n, for one cycle. read_data then holds until the next accepted read.
- fifo_of and fifo_uf are registered: high for exactly the cycle after the offending edge. A continuous illegal request pulses every cycle.
- Flush or rst at edge n: fifo_empty = 1 after edge n. A read_req at edge n+1 underflows.
- Throughput: one write and one read per cycle, sustained at any occupancy.

## Test plan

- Fill/drain (DATA=8, ADDR=4, OVERWRITE=0): write 0x01..0x10 on 16 consecutive cycles.
  - Required: fifo_full = 1 and count = 16 after the 16th edge; fifo_almost_full rises at count 14.
  - Read 16: words 0x01..0x10 in order, each with read_data_valid; fifo_empty = 1 at the end; fifo_almost_empty rises at count 2.
- Overflow drop (OVERWRITE=0): fill with 0x01..0x10, then write 0xAA.
  - Required: fifo_of high one cycle, count stays 16, draining returns 0x01..0x10 with no 0xAA.
- Overwrite (OVERWRITE=1): fill with 0x01..0x10, then write 0xAA and 0xBB.
  - Required: fifo_of pulses twice, count stays 16, draining returns 0x03..0x10, 0xAA, 0xBB.
- Underflow and simultaneous request on empty: read_req and write_req = 0x55 together.
  - Required: fifo_uf pulses, read_data_valid = 0, count = 1; the next read returns 0x55.
- Full plus simultaneous read/write with pointer wrap: hold full and issue read+write of 0x20..0x3F for 32 cycles.
  - Required: count stays 16, no fifo_of, read order continuous across the wrap.
- Flush and reset mid-operation: at count 7, assert flush together with write_req.
  - Required: count = 0, fifo_empty = 1, the write is ignored, and the next read underflows.
  - Then, at count 5, assert rst: all outputs at reset values on the next cycle, including read_data = 0.

Source files
------------

// File: rtl/fifo_ring_param.sv
// Parametrised single-clock circular FIFO with optional overwrite-on-full,
// programmable almost-full/almost-empty thresholds, occupancy count and flush.
module fifo_ring_param #(
  parameter int DATA      = 8,
  parameter int ADDR      = 4,
  parameter int AF_LEVEL  = (1 << ADDR) - 2,
  parameter int AE_LEVEL  = 2,
  parameter int OVERWRITE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [DATA-1:0] write_data,
  input  logic            write_req,
  input  logic            read_req,
  output logic [DATA-1:0] read_data,
  output logic            read_data_valid,
  output logic [ADDR:0]   fifo_count,
  output logic            fifo_empty,
  output logic            fifo_full,
  output logic            fifo_almost_full,
  output logic            fifo_almost_empty,
  output logic            fifo_of,
  output logic            fifo_uf
);

  localparam int            DEPTH      = 1 << ADDR;
  localparam logic [ADDR:0] LP_DEPTH   = DEPTH[ADDR:0];
  localparam logic [ADDR:0] LP_AF      = AF_LEVEL[ADDR:0];
  localparam logic [ADDR:0] LP_AE      = AE_LEVEL[ADDR:0];
  localparam logic [ADDR:0] LP_CNT_ONE = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR-1:0] LP_PTR_ONE = {{(ADDR-1){1'b0}}, 1'b1};
  localparam logic          LP_OVW     = (OVERWRITE != 0);

  logic [DATA-1:0] r_mem [DEPTH];
  logic [ADDR-1:0] r_wr_ptr;
  logic [ADDR-1:0] r_rd_ptr;
  logic [ADDR:0]   r_count;
  logic [DATA-1:0] r_rd_data;
  logic            r_rd_vld;
  logic            r_of;
  logic            r_uf;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovw_wr;
  logic w_push;
  logic w_rd_adv;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == LP_DEPTH);
  assign w_rd_acc = read_req & ~w_empty;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_wr_acc = write_req & (~w_full | w_rd_acc);
  // Overwrite on full: the write lands on the oldest slot and both pointers move.
  assign w_ovw_wr = LP_OVW & write_req & w_full & ~read_req;
  assign w_push   = w_wr_acc | w_ovw_wr;
  assign w_rd_adv = w_rd_acc | w_ovw_wr;

  always_ff @(posedge clk) begin
    if (w_push && !rst && !flush) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_of      <= 1'b0;
      r_uf      <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_vld  <= 1'b0;
      r_of      <= 1'b0;
      r_uf      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + LP_CNT_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - LP_CNT_ONE;
      end
      r_rd_vld <= w_rd_acc;
      r_of     <= write_req & w_full & ~read_req;
      r_uf     <= read_req & w_empty;
    end
  end

  assign read_data         = r_rd_data;
  assign read_data_valid   = r_rd_vld;
  assign fifo_count        = r_count;
  assign fifo_empty        = w_empty;
  assign fifo_full         = w_full;
  assign fifo_almost_full  = (r_count >= LP_AF);
  assign fifo_almost_empty = (r_count <= LP_AE);
  assign fifo_of           = r_of;
  assign fifo_uf           = r_uf;

endmodule

// File: tb/tb_fifo_ring_param.sv
// Bench for fifo_ring_param: a drop-mode and an overwrite-mode instance share
// stimulus and are checked against queue-based reference models.
module tb_fifo_ring_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] write_data;
  logic       write_req;
  logic       read_req;

  logic [7:0] d_rd   [2];
  logic       d_vld  [2];
  logic [4:0] d_cnt  [2];
  logic       d_emp  [2];
  logic       d_full [2];
  logic       d_af   [2];
  logic       d_ae   [2];
  logic       d_of   [2];
  logic       d_uf   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_ring_param #(.DATA(8), .ADDR(4), .AF_LEVEL(14), .AE_LEVEL(2), .OVERWRITE(0)) u_drop (
    .clk(clk), .rst(rst), .flush(flush), .write_data(write_data), .write_req(write_req),
    .read_req(read_req), .read_data(d_rd[0]), .read_data_valid(d_vld[0]), .fifo_count(d_cnt[0]),
    .fifo_empty(d_emp[0]), .fifo_full(d_full[0]), .fifo_almost_full(d_af[0]),
    .fifo_almost_empty(d_ae[0]), .fifo_of(d_of[0]), .fifo_uf(d_uf[0])
  );

  fifo_ring_param #(.DATA(8), .ADDR(4), .AF_LEVEL(14), .AE_LEVEL(2), .OVERWRITE(1)) u_ovw (
    .clk(clk), .rst(rst), .flush(flush), .write_data(write_data), .write_req(write_req),
    .read_req(read_req), .read_data(d_rd[1]), .read_data_valid(d_vld[1]), .fifo_count(d_cnt[1]),
    .fifo_empty(d_emp[1]), .fifo_full(d_full[1]), .fifo_almost_full(d_af[1]),
    .fifo_almost_empty(d_ae[1]), .fifo_of(d_of[1]), .fifo_uf(d_uf[1])
  );

  // Reference model: index 0 drops on full, index 1 overwrites the oldest word.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_rd  [2] = '{8'h00, 8'h00};
  logic       m_vld [2] = '{1'b0, 1'b0};
  logic       m_of  [2] = '{1'b0, 1'b0};
  logic       m_uf  [2] = '{1'b0, 1'b0};

  function automatic int q_size(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] q_pop(input int m);
    if (m == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void q_push(input int m, input logic [7:0] d);
    if (m == 0) q0.push_back(d);
    else q1.push_back(d);
  endfunction

  function automatic void q_clear(input int m);
    if (m == 0) q0.delete();
    else q1.delete();
  endfunction

  task automatic model_step();
    int sz;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        q_clear(m);
        m_rd[m] = 8'h00; m_vld[m] = 1'b0; m_of[m] = 1'b0; m_uf[m] = 1'b0;
      end else if (flush) begin
        q_clear(m);
        m_vld[m] = 1'b0; m_of[m] = 1'b0; m_uf[m] = 1'b0;
      end else begin
        sz = q_size(m);
        m_vld[m] = 1'b0; m_of[m] = 1'b0; m_uf[m] = 1'b0;
        if (read_req) begin
          if (sz == 0) m_uf[m] = 1'b1;
          else begin m_rd[m] = q_pop(m); m_vld[m] = 1'b1; end
        end
        if (write_req) begin
          if (sz == 16 && !read_req) begin
            m_of[m] = 1'b1;
            if (m == 1) begin
              void'(q_pop(m));
              q_push(m, write_data);
            end
          end else begin
            q_push(m, write_data);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic w, input logic [7:0] d,
                       input logic rr);
    rst = r; flush = f; write_req = w; write_data = d; read_req = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 8'h00, 0);
    tick(); tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_rd[m] !== 8'h00 || d_vld[m] !== 1'b0 || d_cnt[m] !== 5'd0 || d_emp[m] !== 1'b1 ||
          d_full[m] !== 1'b0 || d_af[m] !== 1'b0 || d_ae[m] !== 1'b1 || d_of[m] !== 1'b0 ||
          d_uf[m] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_state inst%0d got rd=%h vld=%b cnt=%0d emp=%b full=%b af=%b ae=%b of=%b uf=%b want rd=00 vld=0 cnt=0 emp=1 full=0 af=0 ae=1 of=0 uf=0",
                 m, d_rd[m], d_vld[m], d_cnt[m], d_emp[m], d_full[m], d_af[m], d_ae[m], d_of[m], d_uf[m]);
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 1, 8'(i), 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (d_cnt[m] !== 5'(i) || d_af[m] !== (i >= 14) || d_full[m] !== (i == 16)) begin
          n_errors++;
          $display("FAIL fill inst%0d step%0d got cnt=%0d af=%b full=%b want cnt=%0d af=%b full=%b",
                   m, i, d_cnt[m], d_af[m], d_full[m], i, (i >= 14), (i == 16));
        end
      end
    end
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 8'h00, 1);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (d_vld[m] !== 1'b1 || d_rd[m] !== 8'(i) || d_cnt[m] !== 5'(16 - i) ||
            d_ae[m] !== (16 - i <= 2) || d_emp[m] !== (i == 16)) begin
          n_errors++;
          $display("FAIL drain inst%0d step%0d got vld=%b rd=%h cnt=%0d ae=%b emp=%b want vld=1 rd=%h cnt=%0d ae=%b emp=%b",
                   m, i, d_vld[m], d_rd[m], d_cnt[m], d_ae[m], d_emp[m], 8'(i), 16 - i, (16 - i <= 2), (i == 16));
        end
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d;
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 1, 8'(i), 0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, (k == 0) ? 8'hAA : 8'hBB, 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (d_of[m] !== 1'b1 || d_cnt[m] !== 5'd16) begin
          n_errors++;
          $display("FAIL overflow_pulse inst%0d write%0d got of=%b cnt=%0d want of=1 cnt=16",
                   m, k, d_of[m], d_cnt[m]);
        end
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_of[m] !== 1'b0) begin
        n_errors++;
        $display("FAIL overflow_clear inst%0d got of=%b want of=0", m, d_of[m]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 8'h00, 1);
      tick();
      for (int m = 0; m < 2; m++) begin
        if (m == 0) exp_d = 8'(i + 1);
        else exp_d = (i < 14) ? 8'(i + 3) : ((i == 14) ? 8'hAA : 8'hBB);
        n_checks++;
        if (d_vld[m] !== 1'b1 || d_rd[m] !== exp_d) begin
          n_errors++;
          $display("FAIL overflow_drain inst%0d idx%0d got vld=%b rd=%h want vld=1 rd=%h",
                   m, i, d_vld[m], d_rd[m], exp_d);
        end
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
  endtask

  task automatic test_underflow_simul();
    drive(0, 0, 1, 8'h55, 1);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_uf[m] !== 1'b1 || d_vld[m] !== 1'b0 || d_cnt[m] !== 5'd1 || d_rd[m] !== m_rd[m]) begin
        n_errors++;
        $display("FAIL underflow inst%0d got uf=%b vld=%b cnt=%0d rd=%h want uf=1 vld=0 cnt=1 rd=%h",
                 m, d_uf[m], d_vld[m], d_cnt[m], d_rd[m], m_rd[m]);
      end
    end
    drive(0, 0, 0, 8'h00, 1);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_uf[m] !== 1'b0 || d_vld[m] !== 1'b1 || d_rd[m] !== 8'h55 || d_cnt[m] !== 5'd0) begin
        n_errors++;
        $display("FAIL underflow_followup inst%0d got uf=%b vld=%b rd=%h cnt=%0d want uf=0 vld=1 rd=55 cnt=0",
                 m, d_uf[m], d_vld[m], d_rd[m], d_cnt[m]);
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
  endtask

  task automatic test_full_rw_wrap();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 8'(8'h10 + i), 0);
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      drive(0, 0, 1, 8'(8'h20 + k), 1);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (d_cnt[m] !== 5'd16 || d_of[m] !== 1'b0 || d_vld[m] !== 1'b1 || d_rd[m] !== 8'(8'h10 + k)) begin
          n_errors++;
          $display("FAIL full_rw inst%0d cyc%0d got cnt=%0d of=%b vld=%b rd=%h want cnt=16 of=0 vld=1 rd=%h",
                   m, k, d_cnt[m], d_of[m], d_vld[m], d_rd[m], 8'(8'h10 + k));
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 8'h00, 1);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (d_rd[m] !== 8'(8'h30 + i)) begin
          n_errors++;
          $display("FAIL wrap_drain inst%0d idx%0d got rd=%h want rd=%h", m, i, d_rd[m], 8'(8'h30 + i));
        end
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 8'(8'h60 + i), 0);
      tick();
    end
    drive(0, 1, 1, 8'h77, 0);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_cnt[m] !== 5'd0 || d_emp[m] !== 1'b1 || d_vld[m] !== 1'b0 || d_rd[m] !== 8'h3F) begin
        n_errors++;
        $display("FAIL flush inst%0d got cnt=%0d emp=%b vld=%b rd=%h want cnt=0 emp=1 vld=0 rd=3f",
                 m, d_cnt[m], d_emp[m], d_vld[m], d_rd[m]);
      end
    end
    drive(0, 0, 0, 8'h00, 1);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_uf[m] !== 1'b1 || d_vld[m] !== 1'b0 || d_cnt[m] !== 5'd0) begin
        n_errors++;
        $display("FAIL flush_underflow inst%0d got uf=%b vld=%b cnt=%0d want uf=1 vld=0 cnt=0",
                 m, d_uf[m], d_vld[m], d_cnt[m]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 8'(8'h80 + i), 0);
      tick();
    end
    drive(0, 0, 0, 8'h00, 1);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_cnt[m] !== 5'd5 || d_rd[m] !== 8'h80) begin
        n_errors++;
        $display("FAIL pre_reset inst%0d got cnt=%0d rd=%h want cnt=5 rd=80", m, d_cnt[m], d_rd[m]);
      end
    end
    drive(1, 0, 1, 8'h99, 1);
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_rd[m] !== 8'h00 || d_vld[m] !== 1'b0 || d_cnt[m] !== 5'd0 || d_emp[m] !== 1'b1 ||
          d_full[m] !== 1'b0 || d_af[m] !== 1'b0 || d_ae[m] !== 1'b1 || d_of[m] !== 1'b0 ||
          d_uf[m] !== 1'b0) begin
        n_errors++;
        $display("FAIL midop_reset inst%0d got rd=%h vld=%b cnt=%0d emp=%b full=%b af=%b ae=%b of=%b uf=%b want reset values",
                 m, d_rd[m], d_vld[m], d_cnt[m], d_emp[m], d_full[m], d_af[m], d_ae[m], d_of[m], d_uf[m]);
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
  endtask

  task automatic test_random();
    int wr_pct;
    int rd_pct;
    int sz;
    for (int c = 0; c < 1200; c++) begin
      wr_pct = ((c / 150) % 2 == 0) ? 75 : 30;
      rd_pct = ((c / 150) % 2 == 0) ? 35 : 70;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < wr_pct), 8'($urandom), ($urandom_range(0, 99) < rd_pct));
      tick();
      for (int m = 0; m < 2; m++) begin
        sz = q_size(m);
        n_checks++;
        if (d_cnt[m] !== 5'(sz) || d_emp[m] !== (sz == 0) || d_full[m] !== (sz == 16) ||
            d_af[m] !== (sz >= 14) || d_ae[m] !== (sz <= 2)) begin
          n_errors++;
          $display("FAIL rnd_status inst%0d cyc%0d got cnt=%0d emp=%b full=%b af=%b ae=%b want cnt=%0d",
                   m, c, d_cnt[m], d_emp[m], d_full[m], d_af[m], d_ae[m], sz);
        end
        n_checks++;
        if (d_vld[m] !== m_vld[m] || d_rd[m] !== m_rd[m] || d_of[m] !== m_of[m] || d_uf[m] !== m_uf[m]) begin
          n_errors++;
          $display("FAIL rnd_read inst%0d cyc%0d got vld=%b rd=%h of=%b uf=%b want vld=%b rd=%h of=%b uf=%b",
                   m, c, d_vld[m], d_rd[m], d_of[m], d_uf[m], m_vld[m], m_rd[m], m_of[m], m_uf[m]);
        end
      end
    end
    drive(0, 0, 0, 8'h00, 0);
    tick();
  endtask

  initial begin
    drive(1, 0, 0, 8'h00, 0);
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_full_rw_wrap();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
